slotmaker_cfg_ctrl: RTL and testbench

SLOTMAKER_CFG_CTRL -- requirements
Module: slotmaker_cfg_ctrl

---
 rtl/slotmaker_cfg_pkg.sv | 37 +++
 rtl/slotmaker_config_if.sv | 14 +
 rtl/slotmaker_cfg_ctrl.sv | 159 +++++++++++++++
 tb/tb_slotmaker_cfg_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slotmaker_cfg_pkg.sv
// Shared types and constants for the slotmaker configuration controller.
// SLOTMAKER_CFG_VERIFY_EN adds the CHECK state to the state enum.
package slotmaker_cfg_pkg;

    localparam int unsigned NUM_SLOTS = 7;
    localparam int unsigned CARD_W    = 8;
    localparam int unsigned SLOT_W    = 3;

    typedef logic [CARD_W-1:0] card_t;
    typedef logic [SLOT_W-1:0] slot_t;

    // BOOT is the all-zero encoding so the state register reads 0 in reset
    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        IDLE   = 3'd1,
        WRITE  = 3'd2,
        COMMIT = 3'd3
`ifdef SLOTMAKER_CFG_VERIFY_EN
        ,
        CHECK  = 3'd4
`endif
    } state_e;

    // Card for slot k lives in bits [8k-1:8k-8]; slot 0 has no entry
    function automatic card_t slot_card(input logic [NUM_SLOTS*CARD_W-1:0] cards,
                                        input slot_t slot);
        card_t c;
        c = '0;
        for (int unsigned k = 1; k <= NUM_SLOTS; k++) begin
            if (slot == slot_t'(k)) begin
                c = cards[k*CARD_W-1 -: CARD_W];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/slotmaker_config_if.sv
// Configuration port between the controller and the slotmaker.
interface slotmaker_config_if;
    import slotmaker_cfg_pkg::*;

    slot_t slot;
    logic  wr;
    card_t card_i;
    card_t card_o;
    logic  reconfig;

    modport controller (output slot, output wr, output card_i, output reconfig, input card_o);
    modport slotmaker  (input slot, input wr, input card_i, input reconfig, output card_o);

endinterface

// File: rtl/slotmaker_cfg_ctrl.sv
// Slotmaker configuration controller: boot-time slot table load, host
// slot writes and reconfig pulses.
// Optional macro SLOTMAKER_CFG_VERIFY_EN: read-back CHECK after every write.
module slotmaker_cfg_ctrl
    import slotmaker_cfg_pkg::*;
#(
    parameter logic [NUM_SLOTS*CARD_W-1:0] DEFAULT_CARDS = '0,
    parameter logic                        AUTO_COMMIT   = 1'b1
) (
    input  logic                   clk_logic,
    input  logic                   system_reset_n,
    slotmaker_config_if.controller cfg,
    input  logic                   req_valid,
    input  logic [SLOT_W-1:0]      req_slot,
    input  logic [CARD_W-1:0]      req_card,
    output logic                   req_ready,
    input  logic                   commit_i,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    state_e state_q, state_d;
    slot_t  slot_q, slot_d;
    card_t  card_q, card_d;
    logic   wr_q, wr_d;
    logic   reconfig_q, reconfig_d;
    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   pending_q, pending_d;
    logic   busy_q, busy_d;
    slot_t  boot_slot_q, boot_slot_d;
    logic   boot_mode_q, boot_mode_d;
    logic   write_end;

    // Next-state, request capture and output pulse generation
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        card_d      = card_q;
        wr_d        = 1'b0;
        reconfig_d  = 1'b0;
        done_d      = reconfig_q;
        err_d       = err_q;
        pending_d   = pending_q | commit_i;
        boot_slot_d = boot_slot_q;
        boot_mode_d = boot_mode_q;
        req_ready   = 1'b0;
        write_end   = 1'b0;

        case (state_q)
            BOOT: begin
                // first cycle after reset only arms the boot load
                if (!boot_mode_q) begin
                    boot_mode_d = 1'b1;
                end else begin
                    wr_d        = 1'b1;
                    slot_d      = boot_slot_q;
                    card_d      = slot_card(DEFAULT_CARDS, boot_slot_q);
                    boot_slot_d = boot_slot_q + 3'd1;
                    state_d     = WRITE;
                end
            end
            IDLE: begin
                req_ready = req_valid;
                if (req_valid) begin
                    if (req_slot == '0) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        wr_d    = 1'b1;
                        slot_d  = req_slot;
                        card_d  = req_card;
                        state_d = WRITE;
                    end
                end else if (pending_q) begin
                    state_d = COMMIT;
                end
            end
            WRITE: begin
`ifdef SLOTMAKER_CFG_VERIFY_EN
                state_d = CHECK;
`else
                write_end = 1'b1;
`endif
            end
`ifdef SLOTMAKER_CFG_VERIFY_EN
            CHECK: begin
                if (cfg.card_o != card_q) begin
                    err_d = 1'b1;
                end
                write_end = 1'b1;
            end
`endif
            COMMIT: begin
                reconfig_d = 1'b1;
                pending_d  = commit_i;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // boot wraps to slot 0 after slot 7, which marks the load complete
        if (write_end) begin
            if (boot_mode_q) begin
                if (boot_slot_q != '0) begin
                    state_d = BOOT;
                end else begin
                    boot_mode_d = 1'b0;
                    state_d     = AUTO_COMMIT ? COMMIT : IDLE;
                end
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q     <= BOOT;
            slot_q      <= '0;
            card_q      <= '0;
            wr_q        <= 1'b0;
            reconfig_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            boot_slot_q <= 3'd1;
            boot_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            card_q      <= card_d;
            wr_q        <= wr_d;
            reconfig_q  <= reconfig_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            boot_slot_q <= boot_slot_d;
            boot_mode_q <= boot_mode_d;
        end
    end

    assign cfg.slot     = slot_q;
    assign cfg.card_i   = card_q;
    assign cfg.wr       = wr_q;
    assign cfg.reconfig = reconfig_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_slotmaker_cfg_ctrl.sv
// Self-checking bench for slotmaker_cfg_ctrl (either SLOTMAKER_CFG_VERIFY_EN setting).
module tb_slotmaker_cfg_ctrl;
    import slotmaker_cfg_pkg::*;

`ifdef SLOTMAKER_CFG_VERIFY_EN
    localparam int LAT     = 3;
    localparam int SPACING = 3;
`else
    localparam int LAT     = 2;
    localparam int SPACING = 2;
`endif
    localparam logic [55:0] CARDS = 56'h0000_0000_05_0000;

    typedef struct {
        logic [2:0] slot;
        logic [7:0] card;
        bit         boot;
    } wr_t;

    typedef struct {
        logic [2:0] slot;
        logic [7:0] card;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_slot = '0;
    logic [7:0] req_card = '0;
    logic       commit_i = 1'b0;
    logic       req_ready, busy, done, err;
    bit         corrupt = 1'b0;
    logic [7:0] mem [8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0, recfg_cnt = 0, done_cnt = 0, ready_cnt = 0;
    int accept_cyc = 0, last_wr_cyc = 0, last_recfg_cyc = 0, prev_boot_cyc = 0;
    wr_t exp_q[$];

    slotmaker_config_if cfg ();

    slotmaker_cfg_ctrl #(
        .DEFAULT_CARDS (CARDS),
        .AUTO_COMMIT   (1'b1)
    ) dut (
        .clk_logic      (clk),
        .system_reset_n (rst_n),
        .cfg            (cfg),
        .req_valid      (req_valid),
        .req_slot       (req_slot),
        .req_card       (req_card),
        .req_ready      (req_ready),
        .commit_i       (commit_i),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // slotmaker model: combinational read-back, optionally returning zero
    initial for (int i = 0; i < 8; i++) mem[i] = '0;
    always @(posedge clk) if (cfg.wr) mem[cfg.slot] <= cfg.card_i;
    assign cfg.card_o = corrupt ? 8'h00 : mem[cfg.slot];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: scoreboard for cfg writes, event counters, reset quietness
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            check("rst_quiet", {cfg.wr, cfg.reconfig, busy, done, err, req_ready}, 6'b0);
        end else begin
            if (req_ready) begin
                ready_cnt++;
                accept_cyc = cyc;
            end
            if (cfg.wr) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                check("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_slot", cfg.slot, e.slot);
                    check("wr_card", cfg.card_i, e.card);
                    if (e.boot) begin
                        if (e.slot != 3'd1) check("boot_spacing", cyc - prev_boot_cyc, SPACING);
                        prev_boot_cyc = cyc;
                    end
                end
            end
            if (cfg.reconfig) begin
                recfg_cnt++;
                last_recfg_cyc = cyc;
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_boot();
        for (int k = 1; k <= 7; k++) exp_q.push_back('{3'(k), CARDS[8*k-1 -: 8], 1'b1});
    endtask

    task automatic wait_boot(output bit ok);
        bit seen_busy = 0;
        ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (busy) seen_busy = 1;
            else if (seen_busy) ok = 1;
        end
    endtask

    task automatic host_req(input logic [2:0] s, input logic [7:0] c, input bit hold, output bit ok);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_slot = s; req_card = c;
        if (s != 0) exp_q.push_back('{s, c, 1'b0});
        #1;
        while (!req_ready && n < 20) begin @(posedge clk); #2; n++; end
        ok = req_ready;
        @(posedge clk); #1;
        if (hold) begin @(posedge clk); #1; end
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int lat);
        seen = 0; lat = -1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (done) begin seen = 1; lat = cyc - accept_cyc; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   ok, seen;
        int   lat, w0, r0, d0, rc0;

        vecs[0] = '{3'd4, 8'h2A, 1'b0};
        vecs[1] = '{3'd0, 8'h00, 1'b1};
        vecs[2] = '{3'd7, 8'hFF, 1'b0};
        vecs[3] = '{3'd0, 8'h33, 1'b1};
        vecs[4] = '{3'd1, 8'h00, 1'b0};
        vecs[5] = '{3'd3, 8'h5A, 1'b0};

        // reset state, with req_valid high to expose req_ready
        #3 rst_n = 1'b0;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_slot", cfg.slot, 0);
        check("rst_card_i", cfg.card_i, 0);
        check("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        push_boot();
        d0 = done_cnt; rc0 = recfg_cnt;
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("boot_first_busy", busy, 1);
        check("boot_first_nowr", cfg.wr, 0);
        @(negedge clk);
        check("boot_slot1_wr", {cfg.wr, cfg.slot}, {1'b1, 3'd1});
        wait_boot(ok);
        check("boot_complete", ok, 1);
        repeat (3) @(negedge clk);
        check("boot_writes", wr_cnt, 7);
        check("boot_sb_empty", exp_q.size(), 0);
        check("boot_reconfig", recfg_cnt - rc0, 1);
        check("boot_recfg_after_wr", last_recfg_cyc > last_wr_cyc, 1);
        check("boot_done", done_cnt - d0, 1);
        check("boot_err", err, 0);

        // host request vectors
        for (int i = 0; i < 6; i++) begin
            w0 = wr_cnt; r0 = ready_cnt; d0 = done_cnt;
            host_req(vecs[i].slot, vecs[i].card, vecs[i].slot != 0, ok);
            check("req_ready_seen", ok, 1);
            wait_done(seen, lat);
            check("done_seen", seen, 1);
            check("latency", lat, (vecs[i].slot != 0) ? LAT : 1);
            repeat (2) @(negedge clk);
            check("err", err, vecs[i].exp_err);
            check("wr_count", wr_cnt - w0, vecs[i].slot != 0);
            check("ready_cycles", ready_cnt - r0, 1);
            check("done_count", done_cnt - d0, 1);
            check("sb_empty", exp_q.size(), 0);
            check("idle_busy", busy, 0);
            if (vecs[i].slot != 0) check("slot_hold", {cfg.slot, cfg.card_i}, {vecs[i].slot, vecs[i].card});
        end

        // commit and write in the same IDLE cycle: write first, then one reconfig
        rc0 = recfg_cnt; w0 = wr_cnt;
        @(posedge clk); #1;
        commit_i = 1'b1; req_valid = 1'b1; req_slot = 3'd2; req_card = 8'h6C;
        exp_q.push_back('{3'd2, 8'h6C, 1'b0});
        #1 check("cw_ready", req_ready, 1);
        @(posedge clk); #1;
        commit_i = 1'b0; req_valid = 1'b0;
        for (int n = 0; n < 40 && recfg_cnt == rc0; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("cw_reconfig", recfg_cnt - rc0, 1);
        check("cw_write", wr_cnt - w0, 1);
        check("cw_order", last_recfg_cyc > last_wr_cyc, 1);
        check("cw_sb_empty", exp_q.size(), 0);
        check("cw_busy", busy, 0);

        // single commit request gives one pulse and one done
        rc0 = recfg_cnt; d0 = done_cnt;
        @(posedge clk); #1 commit_i = 1'b1;
        @(posedge clk); #1 commit_i = 1'b0;
        repeat (12) @(negedge clk);
        check("commit1_reconfig", recfg_cnt - rc0, 1);
        check("commit1_done", done_cnt - d0, 1);

        // commit held across the COMMIT cycle leaves pending set: two pulses
        rc0 = recfg_cnt;
        @(posedge clk); #1 commit_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        commit_i = 1'b0;
        repeat (15) @(negedge clk);
        check("commit2_reconfig", recfg_cnt - rc0, 2);

        // read-back mismatch: err only with verify, cleared by next request
        corrupt = 1'b1;
        host_req(3'd6, 8'h11, 1'b0, ok);
        wait_done(seen, lat);
        repeat (2) @(negedge clk);
`ifdef SLOTMAKER_CFG_VERIFY_EN
        check("verify_err", err, 1);
`else
        check("verify_err", err, 0);
`endif
        corrupt = 1'b0;
        host_req(3'd6, 8'h22, 1'b0, ok);
        wait_done(seen, lat);
        repeat (2) @(negedge clk);
        check("verify_err_clear", err, 0);
        check("verify_sb_empty", exp_q.size(), 0);

        // reset during boot slot 5 aborts, then the full load restarts
        @(posedge clk); #1 rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 push_boot();
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (cfg.wr && cfg.slot == 3'd5) seen = 1;
        end
        check("midboot_slot5_seen", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midboot_outputs", {cfg.wr, cfg.reconfig, busy, done, err, req_ready}, 6'b0);
        check("midboot_slot_card", {cfg.slot, cfg.card_i}, 11'b0);
        exp_q.delete();
        w0 = wr_cnt; rc0 = recfg_cnt;
        repeat (3) @(posedge clk);
        #1 push_boot();
        rst_n = 1'b1;
        wait_boot(ok);
        check("reboot_complete", ok, 1);
        repeat (3) @(negedge clk);
        check("reboot_writes", wr_cnt - w0, 7);
        check("reboot_sb_empty", exp_q.size(), 0);
        check("reboot_reconfig", recfg_cnt - rc0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
